// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (PC, IR, control) with valid/ready handshake, optional 2-entry skid, flush and bubble counter.
// Latency 1 cycle; SKID=1 drops in_ready (registered) only when both entries are held, SKID=0 passes out_ready through to in_ready.
module pipe_stage_reg #(
  parameter int                PC_W   = 8,
  parameter int                IR_W   = 32,
  parameter int                CTRL_W = 12,
  parameter int                SKID   = 1,
  parameter logic [IR_W-1:0]   NOP_IR = '0,
  parameter int                CNT_W  = 16,
  localparam int               CW     = (CTRL_W > 0) ? CTRL_W : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [IR_W-1:0]  in_ir,
  input  logic [CW-1:0]    in_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [IR_W-1:0]  out_ir,
  output logic [CW-1:0]    out_ctrl,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] bubbles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  out_pc_q, out_pc_d;
  logic [IR_W-1:0]  out_ir_q, out_ir_d;
  logic [CW-1:0]    out_ctrl_q, out_ctrl_d;
  logic [PC_W-1:0]  skid_pc_q, skid_pc_d;
  logic [IR_W-1:0]  skid_ir_q, skid_ir_d;
  logic [CW-1:0]    skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0] bub_q, bub_d;
  logic             acc, fire;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (SKID != 0) ? (state_q != FULL) : ((state_q == EMPTY) || out_ready);
  assign acc       = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign out_pc    = out_pc_q;
  assign out_ir    = out_ir_q;
  assign out_ctrl  = out_ctrl_q;
  assign occupancy = state_q;
  assign bubbles   = bub_q;

  always_comb begin
    state_d     = state_q;
    out_pc_d    = out_pc_q;
    out_ir_d    = out_ir_q;
    out_ctrl_d  = out_ctrl_q;
    skid_pc_d   = skid_pc_q;
    skid_ir_d   = skid_ir_q;
    skid_ctrl_d = skid_ctrl_q;
    bub_d       = (state_q == EMPTY && bub_q != '1) ? bub_q + 1'b1 : bub_q;

    // Flush kills both entries; out_pc deliberately keeps its last value.
    if (flush) begin
      state_d    = EMPTY;
      out_ir_d   = NOP_IR;
      out_ctrl_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d    = BUSY;
            out_pc_d   = in_pc;
            out_ir_d   = in_ir;
            out_ctrl_d = in_ctrl;
          end
        end
        BUSY: begin
          if (acc && fire) begin
            out_pc_d   = in_pc;
            out_ir_d   = in_ir;
            out_ctrl_d = in_ctrl;
          end else if (acc && SKID != 0) begin
            state_d     = FULL;
            skid_pc_d   = in_pc;
            skid_ir_d   = in_ir;
            skid_ctrl_d = in_ctrl;
          end else if (fire) begin
            state_d    = EMPTY;
            out_ir_d   = NOP_IR;
            out_ctrl_d = '0;
          end
        end
        FULL: begin
          if (fire) begin
            state_d    = BUSY;
            out_pc_d   = skid_pc_q;
            out_ir_d   = skid_ir_q;
            out_ctrl_d = skid_ctrl_q;
          end
        end
        default: begin
          state_d    = EMPTY;
          out_ir_d   = NOP_IR;
          out_ctrl_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      out_pc_q    <= '0;
      out_ir_q    <= NOP_IR;
      out_ctrl_q  <= '0;
      skid_pc_q   <= '0;
      skid_ir_q   <= '0;
      skid_ctrl_q <= '0;
      bub_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_pc_q    <= out_pc_d;
      out_ir_q    <= out_ir_d;
      out_ctrl_q  <= out_ctrl_d;
      skid_pc_q   <= skid_pc_d;
      skid_ir_q   <= skid_ir_d;
      skid_ctrl_q <= skid_ctrl_d;
      bub_q       <= bub_d;
    end
  end

endmodule
